// File: rtl/fc8_sprite_fetch_if.sv
// rtl/fc8_sprite_fetch_if.sv - request, ROM sprite port and line-buffer read signals of fc8_sprite_fetch
interface fc8_sprite_fetch_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [7:0]            req_id;
    logic [3:0]            req_row;
    logic                  req_hflip;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [19:0]           rom_addr;
    logic                  rom_cs;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [3:0]            lb_rd_idx;
    logic [DATA_WIDTH-1:0] lb_rd_data;
    logic [15:0]           lb_opaque;

    modport slave (
        input  req_valid, req_id, req_row, req_hflip, abort, rom_data, lb_rd_idx,
        output req_ready, busy, done, rom_addr, rom_cs, lb_rd_data, lb_opaque
    );

    modport master (
        output req_valid, req_id, req_row, req_hflip, abort, rom_data, lb_rd_idx,
        input  req_ready, busy, done, rom_addr, rom_cs, lb_rd_data, lb_opaque
    );
endinterface

// File: rtl/fc8_sprite_fetch.sv
// rtl/fc8_sprite_fetch.sv - sprite line fetch into a double-buffered line buffer; FC8_SPRITE_HFLIP_EN enables horizontal flip
module fc8_sprite_fetch #(
    parameter logic [19:0] SPRITE_BASE = 20'h40000,
    parameter int          DATA_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fc8_sprite_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [7:0]            id_q;
    logic [3:0]            row_q;
    logic [3:0]            col;
    logic                  pipe_v;
    logic [3:0]            pipe_col;
    logic                  bank_sel;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] bank0 [16];
    logic [DATA_WIDTH-1:0] bank1 [16];
    logic [15:0]           mask0;
    logic [15:0]           mask1;

    logic                  accept;
    logic                  capture;
    logic                  last;
    logic [3:0]            cap_idx;
    logic                  cap_opaque;

`ifdef FC8_SPRITE_HFLIP_EN
    logic hflip_q;
    assign cap_idx = hflip_q ? (4'd15 - pipe_col) : pipe_col;
`else
    logic unused_hflip;
    assign unused_hflip = bus.req_hflip;
    assign cap_idx      = pipe_col;
`endif

    assign accept     = (state == IDLE) && bus.req_valid;
    // pipe_v only ever holds a beat while a fetch is live, so an abort kills it
    assign capture    = pipe_v && !bus.abort;
    assign last       = capture && (pipe_col == 4'd15);
    assign cap_opaque = (bus.rom_data != '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FETCH;
            FETCH:   if (bus.abort) state_nx = IDLE;
                     else if (col == 4'd15) state_nx = DRAIN;
            DRAIN:   if (bus.abort || last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.rom_cs     = (state == FETCH);
    assign bus.rom_addr   = bus.rom_cs ? (SPRITE_BASE + {4'h0, id_q, row_q, col}) : 20'h0;
    assign bus.done       = done_q;
    assign bus.lb_rd_data = bank_sel ? bank1[bus.lb_rd_idx] : bank0[bus.lb_rd_idx];
    assign bus.lb_opaque  = bank_sel ? mask1 : mask0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            id_q     <= '0;
            row_q    <= '0;
            col      <= '0;
            pipe_v   <= 1'b0;
            pipe_col <= '0;
            bank_sel <= 1'b0;
            done_q   <= 1'b0;
            mask0    <= '0;
            mask1    <= '0;
            for (int i = 0; i < 16; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
`ifdef FC8_SPRITE_HFLIP_EN
            hflip_q  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                id_q  <= bus.req_id;
                row_q <= bus.req_row;
                col   <= '0;
`ifdef FC8_SPRITE_HFLIP_EN
                hflip_q <= bus.req_hflip;
`endif
            end else if (state == FETCH) begin
                col <= col + 4'd1;
            end

            // Stage 0 is the issue slot itself; this register marks the beat
            // whose data the ROM presents on rom_data during the next cycle.
            pipe_v   <= bus.rom_cs && !bus.abort;
            pipe_col <= col;

            if (capture) begin
                if (bank_sel) begin
                    bank0[cap_idx] <= bus.rom_data;
                    mask0[cap_idx] <= cap_opaque;
                end else begin
                    bank1[cap_idx] <= bus.rom_data;
                    mask1[cap_idx] <= cap_opaque;
                end
            end

            done_q <= last;
            if (last) bank_sel <= ~bank_sel;
        end
    end
endmodule

// File: tb/tb_fc8_sprite_fetch.sv
// tb/tb_fc8_sprite_fetch.sv - scoreboard bench for fc8_sprite_fetch
module tb_fc8_sprite_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic wrst_n = 1'b0;

    fc8_sprite_fetch_if #(.DATA_WIDTH(8)) bus ();
    fc8_sprite_fetch_if #(.DATA_WIDTH(8)) wbus ();

    fc8_sprite_fetch #(.SPRITE_BASE(20'h40000), .DATA_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    fc8_sprite_fetch #(.SPRITE_BASE(20'hFFF00), .DATA_WIDTH(8)) u_wrap (
        .clk(clk), .rst_n(wrst_n), .bus(wbus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    int rom_mode = 0;
    logic [19:0] exp_q [$];
    logic [19:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input int mode, input logic [19:0] addr);
        case (mode)
            0:       return (addr >= 20'h40000 && addr <= 20'h400FF) ? 8'h05 : 8'h00;
            1:       return (addr[3:0] == 4'h0 || addr[3:0] == 4'hF) ? 8'h06 : 8'h00;
            default: return addr[7:0];
        endcase
    endfunction

    // Garbage while deselected so an unflagged capture shows up in the buffer
    always @(posedge clk) bus.rom_data  <= bus.rom_cs ? rom_fn(rom_mode, bus.rom_addr) : 8'hEE;
    always @(posedge clk) wbus.rom_data <= wbus.rom_cs ? (8'h80 | {4'h0, wbus.rom_addr[3:0]}) : 8'hEE;

    always @(negedge clk) begin
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (bus.rom_cs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rom_addr_unexpected got %h required none", bus.rom_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.rom_addr !== mon_exp) begin
                    errors++;
                    $display("FAIL rom_addr got %h required %h", bus.rom_addr, mon_exp);
                end
            end
        end
    end

    task automatic push_line(input logic [7:0] id, input logic [3:0] row);
        for (int c = 0; c < 16; c++) exp_q.push_back(20'h40000 + {4'h0, id, row, 4'(c)});
    endtask

    task automatic issue(input logic [7:0] id, input logic [3:0] row, input logic hf, input bit hold);
        bit ok = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        bus.req_row   = row;
        bus.req_hflip = hf;
        push_line(id, row);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout got req_ready=0 required 1");
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_count;
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk); #1;
            if (done_count != d0) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout got no done required done");
        end else begin
            checks++;
            if (done_cyc - acc_cyc !== 17) begin
                errors++;
                $display("FAIL done_latency got %0d required 17", done_cyc - acc_cyc);
            end
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_at_done got %b required 1", bus.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rom_cs} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 1000", {bus.req_ready, bus.busy, bus.done, bus.rom_cs});
        end
        checks++;
        if (bus.rom_addr !== 20'h0 || bus.lb_opaque !== 16'h0 || bus.lb_rd_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h mask=%h px=%h required 0", bus.rom_addr, bus.lb_opaque, bus.lb_rd_data);
        end
        rst_n  = 1'b1;
        wrst_n = 1'b1;
    endtask

    task automatic test_solid();
        rom_mode = 0;
        issue(8'd0, 4'd3, 1'b0, 1'b0);
        wait_done();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL solid_addr_count got %0d left required 0", exp_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            bus.lb_rd_idx = 4'(i);
            #1;
            checks++;
            if (bus.lb_rd_data !== 8'h05) begin
                errors++;
                $display("FAIL solid_px[%0d] got %h required 05", i, bus.lb_rd_data);
            end
        end
        checks++;
        if (bus.lb_opaque !== 16'hFFFF) begin
            errors++;
            $display("FAIL solid_mask got %h required ffff", bus.lb_opaque);
        end
    endtask

    task automatic test_frame();
        logic [3:0] idx [3] = '{4'd0, 4'd7, 4'd15};
        logic [7:0] px  [3] = '{8'h06, 8'h00, 8'h06};
        rom_mode = 1;
        issue(8'd1, 4'd5, 1'b0, 1'b0);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            bus.lb_rd_idx = idx[i];
            #1;
            checks++;
            if (bus.lb_rd_data !== px[i]) begin
                errors++;
                $display("FAIL frame_px[%0d] got %h required %h", idx[i], bus.lb_rd_data, px[i]);
            end
        end
        checks++;
        if (bus.lb_opaque !== 16'h8001) begin
            errors++;
            $display("FAIL frame_mask got %h required 8001", bus.lb_opaque);
        end
    endtask

    task automatic test_flip();
        logic [7:0] e0;
        logic [7:0] e15;
`ifdef FC8_SPRITE_HFLIP_EN
        e0 = 8'h1F; e15 = 8'h10;
`else
        e0 = 8'h10; e15 = 8'h1F;
`endif
        rom_mode = 2;
        issue(8'd2, 4'd1, 1'b1, 1'b0);
        wait_done();
        bus.lb_rd_idx = 4'd0;
        #1;
        checks++;
        if (bus.lb_rd_data !== e0) begin
            errors++;
            $display("FAIL flip_px0 got %h required %h", bus.lb_rd_data, e0);
        end
        bus.lb_rd_idx = 4'd15;
        #1;
        checks++;
        if (bus.lb_rd_data !== e15) begin
            errors++;
            $display("FAIL flip_px15 got %h required %h", bus.lb_rd_data, e15);
        end
        checks++;
        if (bus.lb_opaque !== 16'hFFFF) begin
            errors++;
            $display("FAIL flip_mask got %h required ffff", bus.lb_opaque);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int b = 0;
        rom_mode = 2;
        bus.lb_rd_idx = 4'd0;
        d0 = done_count;
        issue(8'd3, 4'd2, 1'b0, 1'b1);
        bus.req_row = 4'd4;
        push_line(8'd3, 4'd4);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk); #1;
            if (b == 0 && bus.req_valid && bus.req_ready) b = cyc + 1;
            if (b != 0 && cyc == b) bus.req_valid = 1'b0;
            if (cyc == acc_cyc + 17 || cyc == acc_cyc + 34) begin
                checks++;
                if (bus.lb_rd_data !== 8'h20) begin
                    errors++;
                    $display("FAIL b2b_front1 cyc+%0d got %h required 20", cyc - acc_cyc, bus.lb_rd_data);
                end
            end
            if (cyc == acc_cyc + 35) begin
                checks++;
                if (bus.lb_rd_data !== 8'h40) begin
                    errors++;
                    $display("FAIL b2b_front2 got %h required 40", bus.lb_rd_data);
                end
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (b - acc_cyc !== 18) begin
            errors++;
            $display("FAIL b2b_second_accept got +%0d required +18", b - acc_cyc);
        end
        checks++;
        if (done_count - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d required 2", done_count - d0);
        end
        checks++;
        if (done_cyc - acc_cyc !== 35) begin
            errors++;
            $display("FAIL b2b_second_done got +%0d required +35", done_cyc - acc_cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_addr_count got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_abort();
        int d0;
        rom_mode = 1;
        bus.lb_rd_idx = 4'd0;
        d0 = done_count;
        issue(8'd1, 4'd5, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        checks++;
        if ({bus.rom_cs, bus.req_ready, bus.busy} !== 3'b010) begin
            errors++;
            $display("FAIL abort_state got cs/ready/busy=%b required 010", {bus.rom_cs, bus.req_ready, bus.busy});
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_count !== d0) begin
            errors++;
            $display("FAIL abort_done got %0d pulses required 0", done_count - d0);
        end
        checks++;
        if (exp_q.size() != 11) begin
            errors++;
            $display("FAIL abort_issued got %0d unissued required 11", exp_q.size());
        end
        exp_q.delete();
        checks++;
        if (bus.lb_opaque !== 16'hFFFF || bus.lb_rd_data !== 8'h40) begin
            errors++;
            $display("FAIL abort_front got mask=%h px=%h required ffff 40", bus.lb_opaque, bus.lb_rd_data);
        end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            wbus.req_valid = 1'b1;
            wbus.req_id    = 8'd1;
            wbus.req_row   = 4'd0;
            @(negedge clk);
            checks++;
            if (wbus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ready got %b required 1", wbus.req_ready);
            end
            @(posedge clk); #1;
            wbus.req_valid = 1'b0;
            if (pass == 0) begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    checks++;
                    if (wbus.rom_cs !== 1'b1 || wbus.rom_addr !== 20'(k)) begin
                        errors++;
                        $display("FAIL wrap_addr[%0d] got cs=%b addr=%h required 1 %h", k, wbus.rom_cs, wbus.rom_addr, 20'(k));
                    end
                end
                for (int k = 0; k < 6 && !seen; k++) begin
                    @(negedge clk);
                    if (wbus.done) seen = 1;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL wrap_done got none required pulse");
                end
                wbus.lb_rd_idx = 4'd5;
                #1;
                checks++;
                if (wbus.lb_rd_data !== 8'h85 || wbus.lb_opaque !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL wrap_line got px=%h mask=%h required 85 ffff", wbus.lb_rd_data, wbus.lb_opaque);
                end
            end else begin
                repeat (7) @(posedge clk);
                #1 wrst_n = 1'b0;
                #1;
                checks++;
                if ({wbus.req_ready, wbus.busy, wbus.done, wbus.rom_cs} !== 4'b1000 || wbus.rom_addr !== 20'h0) begin
                    errors++;
                    $display("FAIL wrap_reset_ctrl got %b addr=%h required 1000 00000",
                             {wbus.req_ready, wbus.busy, wbus.done, wbus.rom_cs}, wbus.rom_addr);
                end
                checks++;
                if (wbus.lb_opaque !== 16'h0 || wbus.lb_rd_data !== 8'h0) begin
                    errors++;
                    $display("FAIL wrap_reset_bank got mask=%h px=%h required 0 0", wbus.lb_opaque, wbus.lb_rd_data);
                end
                @(negedge clk);
                wrst_n = 1'b1;
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.req_row    = '0;
        bus.req_hflip  = 1'b0;
        bus.abort      = 1'b0;
        bus.lb_rd_idx  = '0;
        wbus.req_valid = 1'b0;
        wbus.req_id    = '0;
        wbus.req_row   = '0;
        wbus.req_hflip = 1'b0;
        wbus.abort     = 1'b0;
        wbus.lb_rd_idx = '0;
        test_reset();
        test_solid();
        test_frame();
        test_flip();
        test_back_to_back();
        test_abort();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
